// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: execute/memory pipeline records,
// data-bus request/response records, access size encoding and opcodes.
package memory_stage_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Access size as log2(bytes), matching funct3[1:0].
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] ctl_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    ctl_t            ctl;
    logic [4:0]      dst;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] result;
  } excute_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    ctl_t            ctl;
    logic [4:0]      dst;
    logic [XLEN-1:0] result;
    logic            misalign;
  } memory_data_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    msize_t          size;
    logic [7:0]      strobe;
    logic [XLEN-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic            addr_ok;
    logic            data_ok;
    logic [XLEN-1:0] data;
  } dbus_resp_t;

  // HOLD keeps a completed load while writeback is stalled.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } mstate_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-bus request/response bundle between the memory stage and the bus.
interface memory_stage_if;
  import memory_stage_pkg::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/memory_stage_mem_align.sv
// Byte-lane steering for loads and stores: size/misalign decode, store
// strobe and data shift, load extraction with sign/zero extension.
module mem_align
  import memory_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [2:0]          addr_lo,
  input  logic [2:0]          funct3,
  input  logic [DATA_W-1:0]   rd2,
  input  logic [DATA_W-1:0]   rdata,
  output msize_t              size,
  output logic                misalign,
  output logic [DATA_W/8-1:0] strobe,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   ldata
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SHW    = $clog2(DATA_W);

  // Left-justify the field, then shift back arithmetically or logically.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] raw,
                                               input logic [1:0]        sz,
                                               input logic              uns);
    logic [SHW-1:0]           shamt;
    logic [DATA_W-1:0]        up;
    logic signed [DATA_W-1:0] sx;
    case (sz)
      2'd0:    shamt = SHW'(DATA_W - 8);
      2'd1:    shamt = SHW'(DATA_W - 16);
      2'd2:    shamt = SHW'(DATA_W - 32);
      default: shamt = '0;
    endcase
    up = raw << shamt;
    sx = signed'(up) >>> shamt;
    if (uns) return up >> shamt;
    return sx;
  endfunction

  logic [STRB_W-1:0] mask;

  // Decode access width and steer bytes to/from their lanes.
  always_comb begin
    size = msize_t'({1'b0, funct3[1:0]});
    case (funct3[1:0])
      2'd0: begin
        mask     = STRB_W'(8'h01);
        misalign = 1'b0;
      end
      2'd1: begin
        mask     = STRB_W'(8'h03);
        misalign = addr_lo[0];
      end
      2'd2: begin
        mask     = STRB_W'(8'h0F);
        misalign = |addr_lo[1:0];
      end
      default: begin
        mask     = STRB_W'(8'hFF);
        misalign = |addr_lo;
      end
    endcase
    strobe = mask << addr_lo;
    wdata  = rd2 << {addr_lo, 3'b000};
    ldata  = extend(rdata >> {addr_lo, 3'b000}, funct3[1:0], funct3[2]);
  end

endmodule

// File: rtl/memory_stage.sv
// Memory stage of the 5-stage RV64 core: issues loads/stores on the data
// bus, stalls execute while a transaction is outstanding and registers the
// result into dataM for writeback.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  excute_data_t          dataE,
  output memory_data_t          dataM,
  output logic                  stopm,
  input  logic                  stopw,
  memory_stage_if.master        dbus
);

  mstate_t state, state_n;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                is_load, is_store, is_mem, go;
  logic                misalign;
  msize_t              acc_size;
  logic [DATA_W/8-1:0] strobe;
  logic [DATA_W-1:0]   wdata, ldata, rdata_sel, rdata_hold;
  logic                req_vld, complete, hold_load;
  logic [XLEN-1:0]     res;
  dbus_req_t           req_out;
  logic                vld_p0;
  memory_data_t        pay_p0;

  assign opcode   = dataE.instr[6:0];
  assign funct3   = dataE.instr[14:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = dataE.valid & (is_load | is_store);
  assign go       = is_mem & ~misalign;

  // A load completed under writeback stall is replayed from the hold buffer.
  assign rdata_sel = (state == S_HOLD) ? rdata_hold : dbus.dresp.data;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .addr_lo  (dataE.result[2:0]),
    .funct3   (funct3),
    .rd2      (dataE.rd2),
    .rdata    (rdata_sel),
    .size     (acc_size),
    .misalign (misalign),
    .strobe   (strobe),
    .wdata    (wdata),
    .ldata    (ldata)
  );

  // Bus FSM state register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Bus FSM next state, request valid and completion detect.
  always_comb begin
    state_n   = state;
    req_vld   = 1'b0;
    complete  = 1'b0;
    hold_load = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          req_vld = 1'b1;
          if (!dbus.dresp.addr_ok)     state_n  = S_REQ;
          else if (dbus.dresp.data_ok) complete = 1'b1;
          else                         state_n  = S_WAIT;
        end
      end
      S_REQ: begin
        req_vld = 1'b1;
        if (dbus.dresp.addr_ok) begin
          if (dbus.dresp.data_ok) complete = 1'b1;
          else                    state_n  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dbus.dresp.data_ok) complete = 1'b1;
      end
      default: begin
        complete = 1'b1;
      end
    endcase
    hold_load = complete & (state != S_HOLD);
    if (complete) state_n = stopw ? S_HOLD : S_IDLE;
  end

  // Drive the bus request; valid is forced low while reset is asserted.
  always_comb begin
    req_out        = '0;
    req_out.valid  = req_vld & reset;
    req_out.addr   = dataE.result[ADDR_W-1:0];
    req_out.size   = acc_size;
    req_out.strobe = strobe;
    req_out.data   = wdata;
  end

  assign dbus.dreq = req_out;

  assign stopm = (go & ~complete) | stopw;

  // Select the value written back: load data, zero for stores, else ALU result.
  always_comb begin
    res = dataE.result;
    if (go) res = is_load ? ldata : '0;
  end

  // Capture raw bus data at completion for replay after a writeback stall.
  always_ff @(posedge clk) begin
    if (hold_load) rdata_hold <= dbus.dresp.data;
  end

  // ---- stage boundary: execute -> writeback register (control) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      vld_p0 <= 1'b0;
    else if (!stopw) vld_p0 <= dataE.valid & ~stopm;
  end

  // ---- stage boundary: execute -> writeback register (payload) ----
  always_ff @(posedge clk) begin
    if (!stopw) begin
      pay_p0.valid    <= 1'b0;
      pay_p0.pc       <= dataE.pc;
      pay_p0.instr    <= dataE.instr;
      pay_p0.ctl      <= dataE.ctl;
      pay_p0.dst      <= dataE.dst;
      pay_p0.result   <= res;
      pay_p0.misalign <= is_mem & misalign;
    end
  end

  // Merge the reset-controlled valid with the payload.
  always_comb begin
    dataM       = pay_p0;
    dataM.valid = vld_p0;
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected writeback records are queued
// as ops are driven and compared when dataM presents them.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam logic [6:0] OP_ALU = 7'b0010011;

  logic         clk = 1'b0;
  logic         reset;
  excute_data_t dataE;
  memory_data_t dataM;
  logic         stopm;
  logic         stopw;

  memory_stage_if dbus ();

  memory_stage #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .dataE (dataE),
    .dataM (dataM),
    .stopm (stopm),
    .stopw (stopw),
    .dbus  (dbus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  memory_data_t exp_q[$];

  function automatic excute_data_t mk_op(logic [6:0] opc, logic [2:0] f3, logic [63:0] pc,
                                         logic [4:0] dst, logic [63:0] rd2, logic [63:0] r);
    excute_data_t d;
    d.valid  = 1'b1;
    d.pc     = pc;
    d.instr  = {17'd0, f3, 5'd0, opc};
    d.ctl    = 8'h5A;
    d.dst    = dst;
    d.rd2    = rd2;
    d.result = r;
    return d;
  endfunction

  function automatic memory_data_t mk_exp(excute_data_t d, logic [63:0] r, logic mis);
    memory_data_t m;
    m.valid    = 1'b1;
    m.pc       = d.pc;
    m.instr    = d.instr;
    m.ctl      = d.ctl;
    m.dst      = d.dst;
    m.result   = r;
    m.misalign = mis;
    return m;
  endfunction

  // Wait (bounded, at negedges) for dataM to present a valid record.
  task automatic wait_out(output memory_data_t got, output bit seen);
    seen = 1'b0;
    got  = '0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (dataM.valid === 1'b1) begin
        got  = dataM;
        seen = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    reset      = 1'b0;
    stopw      = 1'b0;
    dataE      = '0;
    dbus.dresp = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (dbus.dreq.valid !== 1'b0 || dataM.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: dreq.valid=%b dataM.valid=%b required 0/0", dbus.dreq.valid, dataM.valid);
    end
    dataE = mk_op(OP_LOAD, 3'b010, 64'h0, 5'd1, 64'h0, 64'h1000);
    #1;
    n_tests++;
    if (dbus.dreq.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_gates_req: dreq.valid=%b required 0", dbus.dreq.valid);
    end
    dataE = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (dataM.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_valid: dataM.valid=%b required 0", dataM.valid);
    end
    dataE       = mk_op(OP_LOAD, 3'b010, 64'h0, 5'd1, 64'h0, 64'h1000);
    dataE.valid = 1'b0;
    #1;
    n_tests++;
    if (dbus.dreq.valid !== 1'b0 || stopm !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_no_req: dreq.valid=%b stopm=%b required 0/0", dbus.dreq.valid, stopm);
    end
    @(negedge clk);
    n_tests++;
    if (dataM.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_bubble: dataM.valid=%b required 0", dataM.valid);
    end
    dataE = '0;
  endtask

  task automatic test_alu;
    memory_data_t got, exp;
    bit seen;
    dataE = mk_op(OP_ALU, 3'b000, 64'h100, 5'd1, 64'h0, 64'h5);
    exp_q.push_back(mk_exp(dataE, 64'h5, 1'b0));
    #1;
    n_tests++;
    if (stopm !== 1'b0 || dbus.dreq.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_ctrl: stopm=%b dreq.valid=%b required 0/0", stopm, dbus.dreq.valid);
    end
    @(negedge clk);
    dataE = '0;
    wait_out(got, seen);
    exp = exp_q.pop_front();
    n_tests++;
    if (!seen || got !== exp) begin
      n_fail++;
      $display("FAIL addi_out: got %h required %h", got, exp);
    end
    @(negedge clk);
    n_tests++;
    if (dataM.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_bubble: dataM.valid=%b required 0", dataM.valid);
    end
  endtask

  task automatic test_lw_fast;
    memory_data_t got, exp;
    bit seen;
    dataE      = mk_op(OP_LOAD, 3'b010, 64'h104, 5'd2, 64'h0, 64'h1004);
    dbus.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h8000_0000_0000_0000};
    exp_q.push_back(mk_exp(dataE, 64'hFFFF_FFFF_8000_0000, 1'b0));
    #1;
    n_tests++;
    if (dbus.dreq.valid !== 1'b1 || dbus.dreq.addr !== 64'h1004 || dbus.dreq.size !== MSIZE4 || stopm !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_fast_req: valid=%b addr=%h size=%0d stopm=%b required 1/1004/%0d/0",
               dbus.dreq.valid, dbus.dreq.addr, dbus.dreq.size, stopm, MSIZE4);
    end
    @(negedge clk);
    dataE      = '0;
    dbus.dresp = '0;
    wait_out(got, seen);
    exp = exp_q.pop_front();
    n_tests++;
    if (!seen || got !== exp) begin
      n_fail++;
      $display("FAIL lw_fast_out: got %h required %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_lbu_slow;
    memory_data_t got, exp;
    bit seen;
    int stall = 0;
    dataE = mk_op(OP_LOAD, 3'b100, 64'h108, 5'd3, 64'h0, 64'h1003);
    exp_q.push_back(mk_exp(dataE, 64'hAB, 1'b0));
    for (int k = 0; k < 6; k++) begin
      dbus.dresp.addr_ok = (k == 2);
      dbus.dresp.data_ok = (k == 5);
      dbus.dresp.data    = (k == 5) ? 64'h0000_0000_AB00_0000 : 64'hDEAD_BEEF_DEAD_BEEF;
      #1;
      if (stopm === 1'b1) stall++;
      n_tests++;
      if (dataM.valid !== 1'b0 || dbus.dreq.valid !== (k <= 2)) begin
        n_fail++;
        $display("FAIL lbu_cycle%0d: dataM.valid=%b dreq.valid=%b required 0/%b", k, dataM.valid, dbus.dreq.valid, k <= 2);
      end
      @(negedge clk);
    end
    dataE      = '0;
    dbus.dresp = '0;
    n_tests++;
    if (stall != 5) begin
      n_fail++;
      $display("FAIL lbu_stall_cycles: got %0d required 5", stall);
    end
    wait_out(got, seen);
    exp = exp_q.pop_front();
    n_tests++;
    if (!seen || got !== exp) begin
      n_fail++;
      $display("FAIL lbu_out: got %h required %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_sh_store;
    memory_data_t got, exp;
    dbus_req_t    rq;
    bit seen;
    dataE = mk_op(OP_STORE, 3'b001, 64'h10C, 5'd0, 64'h1234, 64'h2006);
    exp_q.push_back(mk_exp(dataE, 64'h0, 1'b0));
    rq = '{valid: 1'b1, addr: 64'h2006, size: MSIZE2, strobe: 8'hC0, data: 64'h1234_0000_0000_0000};
    for (int k = 0; k < 4; k++) begin
      dbus.dresp = '{addr_ok: (k == 2), data_ok: (k == 3), data: 64'h0};
      #1;
      n_tests++;
      if (k <= 2 && dbus.dreq !== rq) begin
        n_fail++;
        $display("FAIL sh_req_cycle%0d: got %h required %h", k, dbus.dreq, rq);
      end else if (k == 3 && (stopm !== 1'b0 || dbus.dreq.valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL sh_complete: stopm=%b dreq.valid=%b required 0/0", stopm, dbus.dreq.valid);
      end
      @(negedge clk);
    end
    dataE      = '0;
    dbus.dresp = '0;
    wait_out(got, seen);
    exp = exp_q.pop_front();
    n_tests++;
    if (!seen || got !== exp) begin
      n_fail++;
      $display("FAIL sh_out: got %h required %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign;
    memory_data_t got, exp;
    bit seen;
    dataE = mk_op(OP_LOAD, 3'b011, 64'h110, 5'd4, 64'h0, 64'h3003);
    exp_q.push_back(mk_exp(dataE, 64'h3003, 1'b1));
    #1;
    n_tests++;
    if (dbus.dreq.valid !== 1'b0 || stopm !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_ctrl: dreq.valid=%b stopm=%b required 0/0", dbus.dreq.valid, stopm);
    end
    @(negedge clk);
    dataE = '0;
    wait_out(got, seen);
    exp = exp_q.pop_front();
    n_tests++;
    if (!seen || got !== exp) begin
      n_fail++;
      $display("FAIL misalign_out: got %h required %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_stopw_hold;
    memory_data_t got, exp;
    bit seen;
    dataE      = mk_op(OP_LOAD, 3'b011, 64'h114, 5'd5, 64'h0, 64'h5000);
    stopw      = 1'b1;
    dbus.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h0123_4567_89AB_CDEF};
    exp_q.push_back(mk_exp(dataE, 64'h0123_4567_89AB_CDEF, 1'b0));
    #1;
    n_tests++;
    if (dbus.dreq.valid !== 1'b1 || stopm !== 1'b1) begin
      n_fail++;
      $display("FAIL stopw_issue: dreq.valid=%b stopm=%b required 1/1", dbus.dreq.valid, stopm);
    end
    @(negedge clk);
    dbus.dresp = '{addr_ok: 1'b0, data_ok: 1'b0, data: 64'hFFFF_FFFF_FFFF_FFFF};
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if (dbus.dreq.valid !== 1'b0 || stopm !== 1'b1 || dataM.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stopw_hold%0d: dreq.valid=%b stopm=%b dataM.valid=%b required 0/1/0",
                 k, dbus.dreq.valid, stopm, dataM.valid);
      end
      @(negedge clk);
    end
    stopw = 1'b0;
    #1;
    n_tests++;
    if (stopm !== 1'b0 || dbus.dreq.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stopw_release: stopm=%b dreq.valid=%b required 0/0", stopm, dbus.dreq.valid);
    end
    @(negedge clk);
    dataE      = '0;
    dbus.dresp = '0;
    wait_out(got, seen);
    exp = exp_q.pop_front();
    n_tests++;
    if (!seen || got !== exp) begin
      n_fail++;
      $display("FAIL stopw_out: got %h required %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    memory_data_t got, exp;
    bit seen;
    dataE      = mk_op(OP_LOAD, 3'b010, 64'h118, 5'd6, 64'h0, 64'h4000);
    dbus.dresp = '0;
    @(negedge clk);
    dbus.dresp.addr_ok = 1'b1;
    @(negedge clk);
    dbus.dresp = '0;
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (dbus.dreq.valid !== 1'b0 || dataM.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: dreq.valid=%b dataM.valid=%b required 0/0", dbus.dreq.valid, dataM.valid);
    end
    @(negedge clk);
    reset      = 1'b1;
    dataE      = '0;
    dbus.dresp = '{addr_ok: 1'b0, data_ok: 1'b1, data: 64'hBAD0_BAD0_BAD0_BAD0};
    #1;
    n_tests++;
    if (dbus.dreq.valid !== 1'b0 || stopm !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_data_ok: dreq.valid=%b stopm=%b required 0/0", dbus.dreq.valid, stopm);
    end
    @(negedge clk);
    dbus.dresp = '0;
    n_tests++;
    if (dataM.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_bubble: dataM.valid=%b required 0", dataM.valid);
    end
    dataE      = mk_op(OP_LOAD, 3'b010, 64'h11C, 5'd7, 64'h0, 64'h4008);
    dbus.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: 64'h1234_5678_7FFF_0001};
    exp_q.push_back(mk_exp(dataE, 64'h7FFF_0001, 1'b0));
    #1;
    n_tests++;
    if (stopm !== 1'b0 || dbus.dreq.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL after_reset_lw: stopm=%b dreq.valid=%b required 0/1", stopm, dbus.dreq.valid);
    end
    @(negedge clk);
    dataE      = '0;
    dbus.dresp = '0;
    wait_out(got, seen);
    exp = exp_q.pop_front();
    n_tests++;
    if (!seen || got !== exp) begin
      n_fail++;
      $display("FAIL after_reset_out: got %h required %h", got, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    excute_data_t ops[4];
    logic [63:0]  rdat[4];
    logic [63:0]  rres[4];
    memory_data_t exp;
    ops[0] = mk_op(OP_ALU,   3'b000, 64'h200, 5'd8,  64'h0,  64'h7);
    ops[1] = mk_op(OP_LOAD,  3'b001, 64'h204, 5'd9,  64'h0,  64'h6002);
    ops[2] = mk_op(OP_LOAD,  3'b110, 64'h208, 5'd10, 64'h0,  64'h6004);
    ops[3] = mk_op(OP_STORE, 3'b000, 64'h20C, 5'd0,  64'hAA, 64'h6001);
    rdat[0] = 64'h5555_5555_5555_5555;
    rdat[1] = 64'h0000_0000_8001_0000;
    rdat[2] = 64'hF000_0000_1111_1111;
    rdat[3] = 64'h0;
    rres[0] = 64'h7;
    rres[1] = 64'hFFFF_FFFF_FFFF_8001;
    rres[2] = 64'h0000_0000_F000_0000;
    rres[3] = 64'h0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        exp = exp_q.pop_front();
        n_tests++;
        if (dataM !== exp) begin
          n_fail++;
          $display("FAIL b2b_out%0d: got %h required %h", k - 1, dataM, exp);
        end
      end
      if (k < 4) begin
        dataE      = ops[k];
        dbus.dresp = '{addr_ok: 1'b1, data_ok: 1'b1, data: rdat[k]};
        exp_q.push_back(mk_exp(ops[k], rres[k], 1'b0));
        #1;
        n_tests++;
        if (stopm !== 1'b0 || dbus.dreq.valid !== (k != 0)) begin
          n_fail++;
          $display("FAIL b2b_ctrl%0d: stopm=%b dreq.valid=%b required 0/%b", k, stopm, dbus.dreq.valid, k != 0);
        end
        if (k == 3) begin
          n_tests++;
          if (dbus.dreq.strobe !== 8'h02 || dbus.dreq.data !== 64'hAA00) begin
            n_fail++;
            $display("FAIL sb_lanes: strobe=%h data=%h required 02/000000000000aa00", dbus.dreq.strobe, dbus.dreq.data);
          end
        end
      end else begin
        dataE      = '0;
        dbus.dresp = '0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    dataE      = '0;
    stopw      = 1'b0;
    reset      = 1'b0;
    dbus.dresp = '0;
    test_reset();
    test_alu();
    test_lw_fast();
    test_lbu_slow();
    test_sh_store();
    test_misalign();
    test_stopw_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
